// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data; data wins unless fetch has waited STARVE_LIM grants.
// Done pulse MEM_LAT+2 cycles after grant (1 cycle if out of range); requests wait while busy or halted.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int MEM_BYTES  = 524288,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int LAT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_LIM + 1);
    localparam logic [LAT_W-1:0]  LAT_MAX = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0]  LAT_ONE = LAT_W'(1);
    localparam logic [STV_W-1:0]  STV_MAX = STV_W'(STARVE_LIM);
    localparam logic [STV_W-1:0]  STV_ONE = STV_W'(1);
    localparam logic [ADDR_W:0]   MEM_LIM = (ADDR_W + 1)'(MEM_BYTES);
    localparam logic [ADDR_W:0]   WORD_B  = (ADDR_W + 1)'(8);

    logic [1:0]        state_q, state_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              pick_d;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_oor;

    // Data wins a tie unless fetch has already been passed over STARVE_LIM times.
    assign pick_d   = d_req && !(if_req && (starve_q >= STV_MAX));
    assign sel_addr = pick_d ? d_addr : if_addr;
    assign sel_oor  = ({1'b0, sel_addr} + WORD_B) > MEM_LIM;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        lat_d    = lat_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (!if_req) starve_d = '0;
                if (!halt && (if_req || d_req)) begin
                    owner_d = pick_d;
                    addr_d  = sel_addr;
                    we_d    = pick_d && d_we;
                    wdata_d = pick_d ? d_wdata : '0;
                    rdata_d = '0;
                    if (!pick_d) starve_d = '0;
                    else if (if_req && (starve_q < STV_MAX)) starve_d = starve_q + STV_ONE;
                    if (sel_oor) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                lat_d   = LAT_ONE;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LAT_MAX) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    state_d = S_DONE;
                end else begin
                    lat_d = lat_q + LAT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
            lat_q    <= '0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            lat_q    <= lat_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign owner     = owner_q;

    assign if_done  = (state_q == S_DONE) && !owner_q;
    assign d_done   = (state_q == S_DONE) && owner_q;
    assign if_rdata = if_done ? rdata_q : '0;
    assign if_err   = if_done && err_q;
    assign d_rdata  = d_done ? rdata_q : '0;
    assign d_err    = d_done && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, corner sequences, then random traffic vs a transaction model.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32, DATA_W = 64, MEM_BYTES = 524288, MEM_LAT = 1, STARVE_LIM = 4;

    logic clk, reset, halt;
    logic if_req, if_done, if_err;
    logic [31:0] if_addr;
    logic [63:0] if_rdata;
    logic d_req, d_we, d_done, d_err;
    logic [31:0] d_addr;
    logic [63:0] d_wdata, d_rdata;
    logic mem_en, mem_we, busy, owner;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES),
                       .MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .reset(reset), .halt(halt),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] dflt(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    // Memory with one cycle of read latency, as seen from mem_en.
    logic [63:0] tb_mem [logic [31:0]];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] = mem_wdata;
            else mem_rdata <= tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : dflt(mem_addr);
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [63:0] dwd, input logic h);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd; halt = h;
    endtask

    typedef struct {
        string       nm;
        logic        ireq;
        logic [31:0] ia;
        logic        dreq;
        logic        dwe;
        logic [31:0] da;
        logic [63:0] dwd;
        int          en_cyc;
        logic        we;
        logic [31:0] ma;
        int          done_cyc;
        logic        who;
        logic [63:0] rd;
        logic        err;
    } vec_t;

    // One transaction from IDLE; cycle 0 is the cycle the request is presented.
    task automatic run_vec(input vec_t v);
        int enc, ne, dc;
        logic we_s, who_s, er_s, leak;
        logic [31:0] ma_s;
        logic [63:0] wd_s, rd_s;
        enc = -1; ne = 0; dc = -1; leak = 1'b0;
        we_s = 1'b0; who_s = 1'b0; er_s = 1'b0; ma_s = '0; wd_s = '0; rd_s = '0;
        drive(v.ireq, v.ia, v.dreq, v.dwe, v.da, v.dwd, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            tick;
            if (mem_en) begin
                ne++;
                if (enc < 0) begin
                    enc = c; we_s = mem_we; ma_s = mem_addr; wd_s = mem_wdata;
                end
            end
            if (!if_done && (if_rdata != 0 || if_err)) leak = 1'b1;
            if (!d_done && (d_rdata != 0 || d_err)) leak = 1'b1;
            if ((if_done || d_done) && dc < 0) begin
                dc = c; who_s = d_done;
                rd_s = d_done ? d_rdata : if_rdata;
                er_s = d_done ? d_err : if_err;
                drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        chk_i({v.nm, "_en_cycle"}, enc, v.en_cyc);
        chk_i({v.nm, "_en_count"}, ne, (v.en_cyc < 0) ? 0 : 1);
        if (v.en_cyc >= 0) begin
            chk({v.nm, "_mem"}, 64'({we_s, ma_s}), 64'({v.we, v.ma}));
            if (v.we) chk({v.nm, "_wdata"}, wd_s, v.dwd);
        end
        chk_i({v.nm, "_done_cycle"}, dc, v.done_cyc);
        chk({v.nm, "_result"}, {who_s, er_s, rd_s[61:0]}, {v.who, v.err, v.rd[61:0]});
        chk({v.nm, "_rdata"}, rd_s, v.rd);
        chk({v.nm, "_idle_zero"}, 64'(leak), 64'(0));
    endtask

    vec_t vt[9];
    logic [63:0] shadow [logic [31:0]];
    string exp_s = "DDDDFDDDDF";

    initial begin
        int ifd, ddn, en, nd, last, prev;
        logic [63:0] drd;
        logic any;
        tb_mem[32'h0] = 64'h1122334455667788;
        mem_rdata = '0;
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick; tick;
        chk("reset_ctl", 64'({mem_en, mem_we, if_done, d_done, if_err, d_err, busy, owner}), 64'(0));
        chk("reset_data", if_rdata | d_rdata | mem_wdata | 64'(mem_addr), 64'(0));
        reset = 1'b1;
        tick; tick;

        vt[0] = '{"fetch0",     1, 32'h0,     0, 0, 32'h0,     64'h0,        1, 0, 32'h0,     3, 0, 64'h1122334455667788, 0};
        vt[1] = '{"dwrite100",  0, 32'h0,     1, 1, 32'h100,   64'hDEADBEEF, 1, 1, 32'h100,   3, 1, 64'h0,  0};
        vt[2] = '{"dread100",   0, 32'h0,     1, 0, 32'h100,   64'h0,        1, 0, 32'h100,   3, 1, 64'hDEADBEEF, 0};
        vt[3] = '{"dread_oor",  0, 32'h0,     1, 0, 32'h7FFFC, 64'h0,       -1, 0, 32'h0,     1, 1, 64'h0,  1};
        vt[4] = '{"fetch_oor",  1, 32'h80000, 0, 0, 32'h0,     64'h0,       -1, 0, 32'h0,     1, 0, 64'h0,  1};
        vt[5] = '{"fetch_top",  1, 32'h7FFF8, 0, 0, 32'h0,     64'h0,        1, 0, 32'h7FFF8, 3, 0, dflt(32'h7FFF8), 0};
        vt[6] = '{"tie_data",   1, 32'h40,    1, 0, 32'h48,    64'h0,        1, 0, 32'h48,    3, 1, dflt(32'h48), 0};
        vt[7] = '{"dwrite_top", 0, 32'h0,     1, 1, 32'h7FFF8, 64'hCAFE0001, 1, 1, 32'h7FFF8, 3, 1, 64'h0,  0};
        vt[8] = '{"dwr_oor",    0, 32'h0,     1, 1, 32'hFFFFFFF8, 64'h5,    -1, 0, 32'h0,     1, 1, 64'h0,  1};
        for (int i = 0; i < 9; i++) run_vec(vt[i]);

        // Halt raised while a fetch is in WAIT, with a data request queued behind it.
        drive(1'b1, 32'h300, 1'b0, 1'b0, '0, '0, 1'b0);
        tick; tick;
        halt = 1'b1; d_req = 1'b1; d_addr = 32'h308;
        ifd = -1; ddn = -1; en = -1; drd = '0;
        for (int c = 3; c <= 12; c++) begin
            tick;
            if (if_done && ifd < 0) ifd = c;
            if (d_done && ddn < 0) begin ddn = c; drd = d_rdata; end
            if (mem_en && en < 0) en = c;
            if (c == ifd) if_req = 1'b0;
            if (c == ddn) d_req = 1'b0;
            if (c == 7) halt = 1'b0;
        end
        chk_i("halt_if_done", ifd, 3);
        chk_i("halt_mem_en", en, 8);
        chk_i("halt_d_done", ddn, 10);
        chk("halt_d_rdata", drd, dflt(32'h308));

        // Both requesters held: four data grants, then one fetch.
        drive(1'b1, 32'h200, 1'b1, 1'b0, 32'h208, '0, 1'b0);
        nd = 0; last = -1; prev = 0;
        for (int c = 1; c <= 60 && nd < 10; c++) begin
            tick;
            if (if_done || d_done) begin
                chk({"starve_order_", $sformatf("%0d", nd)}, 64'(d_done ? "D" : "F"), 64'(exp_s[nd]));
                if (last >= 0) chk_i("starve_spacing", c - last, 4);
                last = c; nd++;
            end
        end
        chk_i("starve_done_count", nd, 10);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick; tick; tick; tick;

        // Reset in WAIT of a data read: outputs drop at once and the done never comes.
        drive(1'b0, '0, 1'b1, 1'b0, 32'h400, '0, 1'b0);
        tick; tick;
        prev = int'(owner);
        reset = 1'b0;
        #1;
        chk("rst_wait_pre_owner", 64'(prev), 64'(1));
        chk("rst_wait_outs", 64'({mem_en, mem_we, if_done, d_done, d_err, busy, owner}), 64'(0));
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick; tick;
        reset = 1'b1;
        any = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            if (if_done || d_done || mem_en || busy) any = 1'b1;
        end
        chk("rst_no_done", 64'(any), 64'(0));
        vt[0] = '{"post_reset", 1, 32'h408, 0, 0, 32'h0, 64'h0, 1, 0, 32'h408, 3, 0, dflt(32'h408), 0};
        run_vec(vt[0]);

        // Random traffic against a transaction-level schedule.
        begin
            int t, m_idle_at, m_en_at, m_done_at, m_grant_at, starve;
            logic m_who, m_we, m_err, m_owner, i_act, dd_act, dd_w, dwin, h;
            logic [31:0] m_addr, i_a, dd_a, a;
            logic [63:0] m_wdata, m_rd, dd_wd;
            shadow = tb_mem;
            m_idle_at = 0; m_en_at = -1; m_done_at = -1; m_grant_at = -10; starve = 0;
            m_who = 0; m_we = 0; m_err = 0; m_owner = 0; m_addr = '0; m_wdata = '0; m_rd = '0;
            i_act = 0; dd_act = 0; dd_w = 0; i_a = '0; dd_a = '0; dd_wd = '0;
            for (t = 0; t < 2000; t++) begin
                tick;
                chk("rnd_ctl", 64'({mem_en, if_done, d_done, busy, owner}),
                    64'({t == m_en_at, t == m_done_at && !m_who, t == m_done_at && m_who,
                         t > m_grant_at && t < m_idle_at, m_owner}));
                if (t == m_en_at) begin
                    chk("rnd_mem", 64'({mem_we, mem_addr}), 64'({m_we, m_addr}));
                    if (m_we) chk("rnd_wdata", mem_wdata, m_wdata);
                end
                chk("rnd_if_rdata", if_rdata, (t == m_done_at && !m_who) ? m_rd : 64'h0);
                chk("rnd_d_rdata", d_rdata, (t == m_done_at && m_who) ? m_rd : 64'h0);
                chk("rnd_err", 64'({if_err, d_err}),
                    64'({t == m_done_at && !m_who && m_err, t == m_done_at && m_who && m_err}));
                if (if_done) i_act = 0;
                if (d_done) dd_act = 0;
                if (!i_act && $urandom_range(0, 2) == 0) begin
                    i_act = 1; i_a = rnd_addr();
                end
                if (!dd_act && $urandom_range(0, 2) == 0) begin
                    dd_act = 1; dd_a = rnd_addr(); dd_w = 1'($urandom_range(0, 1));
                    dd_wd = {$urandom, $urandom};
                end
                h = ($urandom_range(0, 9) == 0);
                drive(i_act, i_a, dd_act, dd_w, dd_a, dd_wd, h);
                if (t >= m_idle_at) begin
                    if (!i_act) starve = 0;
                    if (!h && (i_act || dd_act)) begin
                        dwin = dd_act && !(i_act && starve >= STARVE_LIM);
                        if (!dwin) starve = 0;
                        else if (i_act) starve = (starve < STARVE_LIM) ? starve + 1 : STARVE_LIM;
                        a = dwin ? dd_a : i_a;
                        m_grant_at = t; m_owner = dwin; m_who = dwin;
                        m_we = dwin && dd_w; m_addr = a; m_wdata = dd_wd;
                        if (64'(a) + 64'd8 > 64'(MEM_BYTES)) begin
                            m_en_at = -1; m_done_at = t + 1; m_rd = '0; m_err = 1;
                        end else begin
                            m_en_at = t + 1; m_done_at = t + MEM_LAT + 2; m_err = 0;
                            m_rd = m_we ? 64'h0 : (shadow.exists(a) ? shadow[a] : dflt(a));
                            if (m_we) shadow[a] = dd_wd;
                        end
                        m_idle_at = m_done_at + 1;
                    end
                end
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [31:0] rnd_addr();
        int r;
        r = int'($urandom_range(0, 15));
        case (r)
            0: return 32'h7FFF8;
            1: return 32'h80000;
            2: return 32'h7FFFC;
            3: return 32'hFFFFFFF8;
            default: return 32'($urandom_range(0, 31)) * 32'd8;
        endcase
    endfunction

endmodule
